axis_fifo_frame: RTL
====================

# axis_fifo_frame

Parametrised synchronous AXI4-Stream FIFO. It carries `tlast`, reports fill level and programmable almost-full/almost-empty flags, and has an optional frame (store-and-forward) mode. In frame mode, oversize frames are dropped. It sits on the UART byte streams between the APB register block and the UART TX/RX engines, and is the general-purpose buffer for any packetised stream in the design.

## Interface
Parameters:
- `DATA_WIDTH`, 8: `tdata` width in bits; must be ≥1.
- `ADDR_WIDTH`, 4: depth = 2^ADDR_WIDTH words; must be ≥2.
- `FRAME_FIFO`, 0: 0 = word FIFO; 1 = store-and-forward frame mode.
- `AF_LEVEL`, 12: `status_almost_full` = (count ≥ AF_LEVEL); range 1..depth.
- `AE_LEVEL`, 2: `status_almost_empty` = (count ≤ AE_LEVEL); range 0..depth-1.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `s_axis_tdata`  in  DATA_WIDTH: write data.
- `s_axis_tlast`  in  1: end of frame marker; stored with the data.
- `s_axis_tvalid`  in  1: write request.
- `s_axis_tready`  out  1: FIFO accepts a beat this cycle.
- `m_axis_tdata`  out  DATA_WIDTH: read data at the read pointer.
- `m_axis_tlast`  out  1: stored `tlast` of the head word.
- `m_axis_tvalid`  out  1: head word is available.
- `m_axis_tready`  in  1: consumer takes the head word.
- `status_count`  out  ADDR_WIDTH+1: words stored, 0..depth.
- `status_almost_full`  out  1: count ≥ AF_LEVEL.
- `status_almost_empty`  out  1: count ≤ AE_LEVEL.
- `status_good_frame`  out  1: 1-cycle pulse when a frame is committed (frame mode only; otherwise 0).
- `status_bad_frame`  out  1: 1-cycle pulse when a dropped frame's `tlast` is accepted (frame mode only; otherwise 0).

## Operation
- **Storage.** Memory is 2^ADDR_WIDTH × (DATA_WIDTH+1), holding data plus last.
- **Pointers.** `wr_ptr`, `rd_ptr` and `commit_ptr` are each ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1).
  - Address = low ADDR_WIDTH bits.
  - full = MSBs differ and low bits equal.
- **Counts.**
  - count = `wr_ptr - rd_ptr`, ADDR_WIDTH+1 bits. It includes uncommitted words.
  - Flags are combinational from count.
- **Write.** A beat is accepted when `s_axis_tvalid && s_axis_tready`. It is stored at `wr_ptr`, then `wr_ptr` increments.
- **Read.**
  - `m_axis_tdata` and `m_axis_tlast` are read combinationally from `mem[rd_ptr]`.
  - When `m_axis_tvalid && m_axis_tready`, `rd_ptr` increments.
- **Independence.** `s_axis_tready` never depends combinationally on `m_axis_tready`, and vice versa.
- **Word mode (FRAME_FIFO=0).**
  - `s_axis_tready` = !full.
  - `m_axis_tvalid` = (`wr_ptr` != `rd_ptr`).
  - `commit_ptr` is unused.
- **Frame mode (FRAME_FIFO=1).** State machine with states IDLE/WRITE and DROP.
  - IDLE/WRITE, `s_axis_tready`:
    - 1 if !full.
    - 1 if full and `commit_ptr == rd_ptr` (the current frame alone fills the memory).
    - 0 otherwise (backpressure until the reader drains committed frames).
  - Accepted beat with tlast=1 in WRITE: `commit_ptr` <= `wr_ptr`+1, and `status_good_frame` pulses.
  - Accepted beat while full and `commit_ptr == rd_ptr`:
    - The frame is oversize.
    - The beat is discarded and `wr_ptr` <= `commit_ptr`.
    - Go to DROP, or, if this beat has tlast=1, stay in IDLE and pulse `status_bad_frame`.
  - DROP:
    - `s_axis_tready` = 1.
    - All beats are discarded and `wr_ptr` is held.
    - On an accepted tlast beat: pulse `status_bad_frame`, return to IDLE.
  - Read side sees committed data only: `m_axis_tvalid` = (`commit_ptr` != `rd_ptr`).
  - A frame of exactly depth beats is committed, not dropped.

## Timing
- **Reset.** Applies on the edge where `rst`=1. Overrides same-cycle reads and writes.
  - All pointers reset to 0 and the state machine to IDLE.
  - Output values from the cycle after the reset edge: `m_axis_tvalid`=0, `s_axis_tready`=1, `status_count`=0, `status_almost_empty`=1, `status_almost_full`=0, both pulses 0.
  - Memory contents are not reset.
  - Reset mid-frame discards every stored and in-flight word.
- **Latency.**
  - Word mode: a beat accepted at edge N appears on `m_axis_*` after edge N, with zero added cycles (fall-through).
  - Frame mode: the first beat appears after the edge accepting that frame's tlast.
- **Boundaries.**
  - Simultaneous read and write at full in word mode: the write is refused (tready=0), the read proceeds, and tready=1 next cycle.
  - Simultaneous read and write at count 1: count stays 1.
  - Read and write in the same cycle at empty: only the write happens.
- **Throughput.** One beat per cycle each side, sustained, including across pointer wrap.
- **Pulse timing.** `status_good_frame` and `status_bad_frame` are registered; each is high for exactly the one cycle after the qualifying edge.

## Test plan
1. **Fill and drain** (ADDR_WIDTH=4, word mode). Reset, hold `m_axis_tready`=0, write 0x00..0x0F.
   - `s_axis_tready` falls after the 16th beat.
   - count=16, almost_full=1.
   - Drain returns 0x00..0x0F in order with tlast as written; count=0, almost_empty=1.
2. **Wrap-around with random handshakes.** Stream 40 incrementing words with random `s_axis_tvalid`/`m_axis_tready`.
   - Output sequence is identical to input.
   - No beat is lost or duplicated.
   - count never exceeds 16.
3. **Full-boundary concurrency.** At count=16, assert `s_axis_tvalid` and `m_axis_tready` together.
   - One word is read, none is written that cycle.
   - Next cycle the write is accepted; count stays 16.
4. **Frame commit** (FRAME_FIFO=1). Write the 5-beat frame 0xA0..0xA4, tlast on 0xA4.
   - `m_axis_tvalid` stays 0 until the cycle after the 0xA4 edge.
   - `status_good_frame` pulses once.
   - 5 beats out, tlast on 0xA4.
5. **Oversize drop** (FRAME_FIFO=1). Write a 20-beat frame, then a 3-beat frame.
   - `s_axis_tready` stays 1 throughout.
   - Nothing is output for the first frame, and `status_bad_frame` pulses after beat 20.
   - Only the 3-beat frame is output.
6. **Reset mid-frame.** Assert `rst` for one cycle after 7 beats of an uncommitted frame.
   - count=0, `m_axis_tvalid`=0.
   - The next frame passes intact.

Source files
------------

// File: rtl/axis_fifo_frame_if.sv
// AXI4-Stream beat bundle (data, last, valid/ready) used for both FIFO ports.
interface axis_fifo_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_fifo_frame.sv
// Synchronous AXI4-Stream FIFO with tlast, fill-level flags and an optional
// store-and-forward frame mode that drops frames larger than the memory.
module axis_fifo_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FRAME_FIFO = 0,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_fifo_frame_if.slave      s_axis,
    axis_fifo_frame_if.master     m_axis,
    output logic [ADDR_WIDTH:0]   status_count,
    output logic                  status_almost_full,
    output logic                  status_almost_empty,
    output logic                  status_good_frame,
    output logic                  status_bad_frame
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_THRESH = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_THRESH = AE_LEVEL[ADDR_WIDTH:0];

    typedef enum logic {ST_IDLE, ST_DROP} state_e;

    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH:0] rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0] commitPtr_q, commitPtr_d;
    state_e              state_q, state_d;
    logic                goodFrame_q, goodFrame_d;
    logic                badFrame_q, badFrame_d;
    logic                full, sReady, mValid, writeAccept, memWrite;

    assign full = (wrPtr_q[ADDR_WIDTH] != rdPtr_q[ADDR_WIDTH]) &&
                  (wrPtr_q[ADDR_WIDTH-1:0] == rdPtr_q[ADDR_WIDTH-1:0]);

    // When full and nothing is committed, the frame in flight can never fit: accept to drop it.
    always_comb begin
        if (FRAME_FIFO != 0) begin
            sReady = (state_q == ST_DROP) || !full || (commitPtr_q == rdPtr_q);
            mValid = (commitPtr_q != rdPtr_q);
        end else begin
            sReady = !full;
            mValid = (wrPtr_q != rdPtr_q);
        end
    end

    assign writeAccept = s_axis.tvalid && sReady;

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        commitPtr_d = commitPtr_q;
        state_d     = state_q;
        goodFrame_d = 1'b0;
        badFrame_d  = 1'b0;
        memWrite    = 1'b0;

        if (mValid && m_axis.tready) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end

        if (FRAME_FIFO == 0) begin
            if (writeAccept) begin
                memWrite = 1'b1;
                wrPtr_d  = wrPtr_q + 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (writeAccept) begin
                        if (full) begin
                            wrPtr_d = commitPtr_q;
                            if (s_axis.tlast) begin
                                badFrame_d = 1'b1;
                            end else begin
                                state_d = ST_DROP;
                            end
                        end else begin
                            memWrite = 1'b1;
                            wrPtr_d  = wrPtr_q + 1'b1;
                            if (s_axis.tlast) begin
                                commitPtr_d = wrPtr_q + 1'b1;
                                goodFrame_d = 1'b1;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (writeAccept && s_axis.tlast) begin
                        badFrame_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            commitPtr_q <= '0;
            state_q     <= ST_IDLE;
            goodFrame_q <= 1'b0;
            badFrame_q  <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            commitPtr_q <= commitPtr_d;
            state_q     <= state_d;
            goodFrame_q <= goodFrame_d;
            badFrame_q  <= badFrame_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            mem_q[wrPtr_q[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    assign {m_axis.tlast, m_axis.tdata} = mem_q[rdPtr_q[ADDR_WIDTH-1:0]];
    assign m_axis.tvalid       = mValid;
    assign s_axis.tready       = sReady;
    assign status_count        = wrPtr_q - rdPtr_q;
    assign status_almost_full  = (status_count >= AF_THRESH);
    assign status_almost_empty = (status_count <= AE_THRESH);
    assign status_good_frame   = goodFrame_q;
    assign status_bad_frame    = badFrame_q;
endmodule
